// File: rtl/m_dbus_pkg.sv
// Shared data-bus types and the store byte-enable legality check.
package m_dbus_pkg;

  typedef enum logic [1:0] {
    ST_BYTE = 2'b00,
    ST_HALF = 2'b01,
    ST_WORD = 2'b10,
    ST_NONE = 2'b11
  } st_ops_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dbus_state_e;

  // True when the lane enables match the store width the core claims to issue.
  function automatic logic be_legal(st_ops_e st_ops, logic [3:0] byte_en);
    logic ok;
    ok = 1'b0;
    case (st_ops)
      ST_BYTE: ok = $onehot(byte_en);
      ST_HALF: ok = (byte_en == 4'b0011) || (byte_en == 4'b1100);
      ST_WORD: ok = (byte_en == 4'b1111);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/m_dbus_sram.sv
// Single-port RAM, synchronous read, per-byte write enables. Contents are not reset.
module m_dbus_sram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];

  // Lane-merged write and registered read on the same enabled cycle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/m_dbus_mem_responder.sv
// Memory end of the core data bus: one request at a time, programmable wait, held response.
module m_dbus_mem_responder
  import m_dbus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_byte_en_i,
  input  logic [1:0]  req_st_ops_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dbus_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          active_q;
  logic          capture;

  logic          req_we_q;
  logic [29:0]   req_word_q;
  logic [31:0]   req_wdata_q;
  logic [3:0]    req_be_q;
  st_ops_e       req_ops_q;

  logic          rsp_err_q, rsp_err_d;
  logic          rsp_load_q, rsp_load_d;

  logic          cur_we;
  logic [29:0]   cur_word;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  st_ops_e       cur_ops;
  logic          cur_err;
  logic          enter_resp;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  // Byte offset within the word is meaningless to a word-wide RAM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];

  // In IDLE the live inputs are used so a zero-wait request can hit the RAM on its accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we_i;
      cur_word  = req_addr_i[31:2];
      cur_wdata = req_wdata_i;
      cur_be    = req_byte_en_i;
      cur_ops   = st_ops_e'(req_st_ops_i);
    end else begin
      cur_we    = req_we_q;
      cur_word  = req_word_q;
      cur_wdata = req_wdata_q;
      cur_be    = req_be_q;
      cur_ops   = req_ops_q;
    end
    cur_err = ((cur_word >> ADDR_W) != '0) || (cur_we && !be_legal(cur_ops, cur_be));
  end

  // Next-state, wait counter and capture strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (active_q && req_valid_i) begin
          capture = 1'b1;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WaitLast) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM is touched only on the edge that enters RESP; errors suppress the write.
  always_comb begin
    enter_resp = (state_d == RESP) && (state_q != RESP);
    ram_we     = (cur_we && !cur_err) ? cur_be : 4'b0000;
    rsp_err_d  = enter_resp ? cur_err : rsp_err_q;
    rsp_load_d = enter_resp ? (!cur_we && !cur_err) : rsp_load_q;
  end

  // FSM, counter and response flag registers; active_q keeps req_ready low until after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      active_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= 1'b1;
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
    end
  end

  // Request capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_ops_q   <= ST_NONE;
    end else if (capture) begin
      req_we_q    <= req_we_i;
      req_word_q  <= req_addr_i[31:2];
      req_wdata_q <= req_wdata_i;
      req_be_q    <= req_byte_en_i;
      req_ops_q   <= st_ops_e'(req_st_ops_i);
    end
  end

  m_dbus_sram #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk    (clk),
    .en_i   (enter_resp),
    .we_i   (ram_we),
    .addr_i (cur_word[ADDR_W-1:0]),
    .wdata_i(cur_wdata),
    .rdata_o(ram_rdata)
  );

  assign req_ready_o = active_q && (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && rsp_err_q;
  assign rsp_rdata_o = (rsp_valid_o && rsp_load_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_m_dbus_mem_responder.sv
// Scoreboard bench: three responders (WAIT_CYCLES 1, 0, 3) driven by directed and random traffic.
module tb_m_dbus_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int w, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (WAIT_CYCLES=%0d): actual %h required %h", name, w, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned W  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int unsigned AW = 12;

    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic [1:0]  req_ops;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    bit          done;

    exp_t        exp_q[$];
    logic [31:0] mem_m [int unsigned];

    m_dbus_mem_responder #(
      .ADDR_W     (AW),
      .WAIT_CYCLES(W)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_byte_en_i(req_be),
      .req_st_ops_i (req_ops),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_err_o    (rsp_err)
    );

    // Monitor: every response handshake consumes one expected entry.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", W, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", W, rsp_rdata, e.rdata);
          chk("rsp_err", W, {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
    end

    // Reference: word memory with byte-lane merge and the store legality rules.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [1:0] ops, output exp_t e);
      int unsigned word;
      bit legal;
      word    = addr / 4;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      if (addr >= (32'd4 << AW)) begin
        e.err = 1'b1;
      end else if (we) begin
        legal = (ops == 2'd0 && $countones(be) == 1) ||
                (ops == 2'd1 && (be == 4'h3 || be == 4'hC)) ||
                (ops == 2'd2 && be == 4'hF);
        if (!legal) begin
          e.err = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_m[word][8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end else begin
        e.rdata = mem_m[word];
      end
    endtask

    task automatic wait_accept(output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      ok = req_ready;
      if (!ok) chk("accept_timeout", W, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [1:0] ops, input int hold);
      exp_t e;
      bit ok;
      int lat;
      logic [31:0] r0;
      logic e0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_ops   = ops;
      wait_accept(ok);
      if (!ok) return;
      model_apply(we, addr, wdata, be, ops, e);
      exp_q.push_back(e);
      // Latency counted in edges, the accept edge included.
      lat = 1;
      while (!rsp_valid && lat < int'(W) + 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("rsp_latency", W, lat, W + 1);
      if (!rsp_valid) return;
      chk("resp_no_ready", W, {30'b0, rsp_valid, req_ready}, 32'd2);
      r0 = rsp_rdata;
      e0 = rsp_err;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_ctrl", W, {29'b0, rsp_valid, req_ready, rsp_err}, {29'b0, 1'b1, 1'b0, e0});
        chk("hold_rdata", W, rsp_rdata, r0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("after_hs", W, {30'b0, rsp_valid, req_ready}, 32'd1);
    endtask

    // Reset while the sw 0xDEADBEEF @0x20 is outstanding.
    task automatic do_abort();
      exp_t e;
      bit ok;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hDEADBEEF;
      req_be    = 4'hF;
      req_ops   = 2'b10;
      wait_accept(ok);
      // With no wait the write lands on the accept edge, before reset can intervene.
      if (W == 0) model_apply(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 2'b10, e);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", W, {30'b0, rsp_valid, req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_abort", W, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
      logic        we;
      logic [31:0] a;
      logic [3:0]  be;
      logic [1:0]  ops;
      done      = 1'b0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      req_ops   = 2'b0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", W, {29'b0, req_ready, rsp_valid, rsp_err}, 32'd0);
      chk("reset_rdata", W, rsp_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", W, {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < 16; i++) do_txn(1'b1, i * 4, $urandom, 4'hF, 2'b10, 0);

      do_txn(1'b1, 32'h10, 32'h11223344, 4'hF, 2'b10, 0);
      do_txn(1'b1, 32'h13, 32'hAA000000, 4'h8, 2'b00, 0);
      do_txn(1'b1, 32'h10, 32'h0000BEEF, 4'h3, 2'b01, 0);
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 0);

      do_txn(1'b1, 32'h10, 32'h55555555, 4'h6, 2'b01, 0);
      do_txn(1'b1, 32'h10, 32'h66666666, 4'h7, 2'b10, 0);
      do_txn(1'b1, 32'h10, 32'h77777777, 4'h0, 2'b11, 0);
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 0);

      do_txn(1'b0, 32'h4000, 32'h0, 4'h0, 2'b00, 0);
      do_txn(1'b1, 32'h4000, 32'h12345678, 4'hF, 2'b10, 0);
      do_txn(1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 0);

      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 5);

      for (int i = 0; i < 40; i++) begin
        we  = 1'($urandom_range(0, 1));
        a   = $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(31, AW + 2));
        ops = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
          case (ops)
            2'd0:    be = 4'd1 << $urandom_range(0, 3);
            2'd1:    be = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'hC;
            2'd2:    be = 4'hF;
            default: be = 4'h0;
          endcase
        end else begin
          be = 4'($urandom_range(0, 15));
        end
        do_txn(we, a, $urandom, be, ops, $urandom_range(0, 3));
      end

      do_abort();
      do_txn(1'b0, 32'h20, 32'h0, 4'h0, 2'b00, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", W, exp_q.size(), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: actual not done required done");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
